fifo_gearbox: RTL and testbench
===============================

# fifo_gearbox

Parametrised wide-to-narrow stream converter between the LDPC encoder core and the narrow output bus: buffers up to DEPTH codewords of IN_WIDTH bits and emits them MSB-first as OUT_WIDTH-bit beats. It uses valid/ready on both sides and has two modes. PAD zero-fills the final beat of each codeword. PACK concatenates codewords into a continuous bitstream. It replaces the fixed 4-deep, no-backpressure serializer used up to now.

## Interface
- IN_WIDTH, 648, codeword width in bits; must be ≥ OUT_WIDTH.
- OUT_WIDTH, 32, output beat width in bits.
- DEPTH, 4, buffer depth in codewords; power of two, ≥ 2.
- MODE, GB_PAD, GB_PAD or GB_PACK (enum from package).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered data.
- in_valid  in  1  in_data holds a codeword.
- in_ready  out  1  codeword accepted on in_valid && in_ready.
- in_data  in  IN_WIDTH  codeword; bit IN_WIDTH-1 is transmitted first.
- out_valid  out  1  out_data holds a beat.
- out_ready  in  1  beat consumed on out_valid && out_ready.
- out_data  out  OUT_WIDTH  beat; bit OUT_WIDTH-1 is the earliest bit.
- out_last  out  1  beat carries the final bit of a codeword.
- level  out  $clog2(DEPTH+1)  codewords held, including a partially drained head.

## Operation
- Storage: DEPTH × IN_WIDTH register array with write pointer wp and read pointer rp (both $clog2(DEPTH) bits, wrapping), level counter, and bit offset off (0..IN_WIDTH-1) into the head entry.
- BEATS = ceil(IN_WIDTH/OUT_WIDTH) = 21 and REM = IN_WIDTH mod OUT_WIDTH = 8 at the defaults.
- PAD mode, beat k of the head entry:
  - out_data = entry[IN_WIDTH-1-k·OUT_WIDTH -: OUT_WIDTH].
  - The last beat carries the REM remaining bits in its MSBs and zeros in its LSBs, with out_last = 1.
  - The head entry is popped on that beat; off returns to 0.
- PACK mode:
  - A beat that runs past the end of the head entry takes its LSBs from the MSBs of the next entry.
  - out_valid requires level ≥ 2 for such a spanning beat and level ≥ 1 otherwise.
  - On each beat, off advances by OUT_WIDTH modulo IN_WIDTH. The head is popped when off wraps.
  - out_last = 1 on the beat containing the head entry's bit 0.
- in_ready = !rst && level < DEPTH. It is a function of registered state only: no same-cycle bypass from a pop.
- Push and pop in the same cycle: level is unchanged and both pointers advance.
- flush: next edge sets level, wp, rp and off to 0. A handshake in the flush cycle is ignored.
- Reset (async, any time, including mid-codeword): level = 0, wp = rp = off = 0, out_valid = 0, out_last = 0, out_data = 0, in_ready = 0 while rst is high. Array contents are not reset.

## Timing
- No combinational path from in_valid to out_valid, or from out_ready to in_ready or out_valid. out_* are decoded from registered state.
- Latency: a codeword pushed at edge N gives out_valid = 1 in the cycle following edge N (empty buffer, or PACK spanning beat waiting on it).
- While out_valid && !out_ready, out_data and out_last hold stable.
- Throughput: one beat per cycle, and one codeword per cycle accepted while level < DEPTH.
- in_ready rises the cycle after the pop that brings level below DEPTH.

## Structure
- Package gearbox_pkg:
  - gearbox_mode_e {GB_PAD, GB_PACK}.
  - Functions gb_beats(in_w, out_w) and gb_rem(in_w, out_w).
- Sub-module gearbox_extract: combinational; takes head entry, next entry, off and MODE; returns out_data, out_last and a span flag.
- Top level holds pointers, level, off and the array.

## Test plan
- PAD, one codeword A = 648'h{pattern}, out_ready = 1 → 21 beats. Beat0 = A[647:616], beat20 = {A[7:0], 24'h0} with out_last on beat20 only. level goes 1→0 after beat20.
- Fill, out_ready = 0, push 5 codewords → first 4 accepted, level = 4, in_ready = 0 with the 5th held. Draining 20 beats keeps in_ready low. in_ready = 1 the cycle after beat 21.
- PACK, push A and B, out_ready = 1:
  - beat20 = {A[7:0], B[647:624]} with out_last.
  - beat40 = {B[15:0], C[647:632]} stalls with out_valid = 0 until C is pushed, then appears one cycle later with out_last.
- Random out_ready (50%) over 16 codewords in each mode → scoreboard bitstream matches; out_data is stable during every stall.
- level = 2, push on the cycle of the head's final beat → level stays 2, wp and rp both advance, and the next beat is beat0 of the next entry.
- Assert flush mid-codeword (beat 7), then reassert rst mid-codeword → level = 0, out_valid = 0 next edge (flush) or immediately (rst). A new codeword afterwards starts at beat0.

Source files
------------

// File: rtl/gearbox_pkg.sv
// Shared types and helpers for the codeword-to-beat gearbox.
package gearbox_pkg;

  typedef enum logic {
    GB_PAD  = 1'b0,
    GB_PACK = 1'b1
  } gearbox_mode_e;

  function automatic int gb_beats(int in_w, int out_w);
    return (in_w + out_w - 1) / out_w;
  endfunction

  function automatic int gb_rem(int in_w, int out_w);
    return in_w % out_w;
  endfunction

endpackage

// File: rtl/gearbox_extract.sv
// Combinational beat selector: picks OUT_WIDTH bits at bit offset off_i of the head entry,
// filling past its end with zeros (PAD) or with the MSBs of the next entry (PACK).
module gearbox_extract
  import gearbox_pkg::*;
#(
  parameter int            IN_WIDTH  = 648,
  parameter int            OUT_WIDTH = 32,
  parameter int            OFF_W     = 10,
  parameter gearbox_mode_e MODE      = GB_PAD
) (
  input  logic [IN_WIDTH-1:0]  head_i,
  input  logic [IN_WIDTH-1:0]  next_i,
  input  logic [OFF_W-1:0]     off_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 last_o,
  output logic                 span_o
);

  // Offset at which the beat reaches exactly the final bit of the head entry.
  localparam logic [OFF_W:0] LAST_OFF = (OFF_W + 1)'(IN_WIDTH - OUT_WIDTH);

  logic [IN_WIDTH-1:0]   tail;
  logic [2*IN_WIDTH-1:0] window;

  always_comb begin
    tail   = (MODE == GB_PACK) ? next_i : '0;
    window = {head_i, tail} << off_i;
    data_o = window[2*IN_WIDTH-1 -: OUT_WIDTH];
    last_o = ({1'b0, off_i} >= LAST_OFF);
    span_o = (MODE == GB_PACK) && ({1'b0, off_i} > LAST_OFF);
  end

endmodule

// File: rtl/fifo_gearbox.sv
// Wide-to-narrow stream converter: DEPTH-entry codeword buffer drained MSB-first as beats.
// Handshakes: a transfer happens on each rising edge where valid && ready are both high.
module fifo_gearbox
  import gearbox_pkg::*;
#(
  parameter int            IN_WIDTH  = 648,
  parameter int            OUT_WIDTH = 32,
  parameter int            DEPTH     = 4,
  parameter gearbox_mode_e MODE      = GB_PAD
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_WIDTH-1:0]          in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int OFF_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);
  localparam logic [OFF_W:0]   STEP    = (OFF_W + 1)'(OUT_WIDTH);
  localparam logic [OFF_W:0]   WRAP    = (OFF_W + 1)'(IN_WIDTH);

  logic [IN_WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]     wp_q, wp_d, rp_q, rp_d, rp_next;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [OFF_W-1:0]     off_q, off_d;
  logic [OFF_W:0]       off_sum;

  logic [OUT_WIDTH-1:0] beat_data;
  logic                 beat_last, beat_span, beat_ok;
  logic                 push, beat_fire, pop;

  assign rp_next = rp_q + 1'b1;

  gearbox_extract #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .OFF_W     (OFF_W),
    .MODE      (MODE)
  ) u_extract (
    .head_i (mem_q[rp_q]),
    .next_i (mem_q[rp_next]),
    .off_i  (off_q),
    .data_o (beat_data),
    .last_o (beat_last),
    .span_o (beat_span)
  );

  // A spanning beat needs the following codeword to be resident as well.
  assign beat_ok   = (level_q != '0) && (!beat_span || (level_q > ONE_L));
  assign out_valid = beat_ok;
  assign out_data  = beat_ok ? beat_data : '0;
  assign out_last  = beat_ok && beat_last;
  assign in_ready  = !rst && (level_q < DEPTH_L);
  assign level     = level_q;

  assign push      = in_valid && in_ready && !flush;
  assign beat_fire = beat_ok && out_ready && !flush;
  assign pop       = beat_fire && beat_last;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    off_d   = off_q;
    off_sum = {1'b0, off_q} + STEP;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
      off_d   = '0;
    end else begin
      if (push) wp_d = wp_q + 1'b1;
      if (pop)  rp_d = rp_next;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      if (beat_fire) begin
        if (!beat_last)            off_d = off_sum[OFF_W-1:0];
        else if (MODE == GB_PACK)  off_d = OFF_W'(off_sum - WRAP);
        else                       off_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      off_q   <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      off_q   <= off_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_data;
  end

endmodule

// File: tb/tb_fifo_gearbox.sv
// Bench for fifo_gearbox: one PAD and one PACK instance share the stimulus, outputs are
// selected by sel_pack; expectations come from a bit-level stream model.
module tb_fifo_gearbox;
  import gearbox_pkg::*;

  localparam int IW    = 648;
  localparam int OW    = 32;
  localparam int DEPTH = 4;
  localparam int REM   = IW % OW;
  localparam int LW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic sel_pack = 1'b0;

  logic p_in_ready, p_out_valid, p_out_last, k_in_ready, k_out_valid, k_out_last;
  logic [OW-1:0] p_out_data, k_out_data;
  logic [LW-1:0] p_level, k_level;

  logic in_ready, out_valid, out_last;
  logic [OW-1:0] out_data;
  logic [LW-1:0] level;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed { logic b; logic e; } mbit_t;
  mbit_t bq[$];
  logic [OW:0] exp_q[$];
  int m_level = 0;

  always #5 clk = ~clk;

  fifo_gearbox #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .MODE(GB_PAD)) dut_pad (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(p_in_ready),
    .in_data(in_data), .out_valid(p_out_valid), .out_ready(out_ready),
    .out_data(p_out_data), .out_last(p_out_last), .level(p_level));

  fifo_gearbox #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .MODE(GB_PACK)) dut_pack (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(k_in_ready),
    .in_data(in_data), .out_valid(k_out_valid), .out_ready(out_ready),
    .out_data(k_out_data), .out_last(k_out_last), .level(k_level));

  assign in_ready  = sel_pack ? k_in_ready  : p_in_ready;
  assign out_valid = sel_pack ? k_out_valid : p_out_valid;
  assign out_last  = sel_pack ? k_out_last  : p_out_last;
  assign out_data  = sel_pack ? k_out_data  : p_out_data;
  assign level     = sel_pack ? k_level     : p_level;

  // ---------------- reference model ----------------
  function automatic logic [IW-1:0] rand_cw();
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < (IW + 31) / 32; i++) r = (r << 32) | IW'($urandom());
    return r;
  endfunction

  function automatic void model_clear();
    bq.delete();
    exp_q.delete();
    m_level = 0;
  endfunction

  // Codeword bits enter a serial stream; PAD re-aligns the stream after each codeword.
  function automatic void model_push(logic [IW-1:0] cw);
    mbit_t m;
    logic [OW-1:0] d;
    logic l;
    for (int i = IW - 1; i >= 0; i--) begin
      m.b = cw[i];
      m.e = (i == 0);
      bq.push_back(m);
    end
    if (!sel_pack) begin
      while (bq.size() % OW != 0) begin
        m.b = 1'b0;
        m.e = 1'b0;
        bq.push_back(m);
      end
    end
    while (bq.size() >= OW) begin
      d = '0;
      l = 1'b0;
      for (int j = 0; j < OW; j++) begin
        m = bq.pop_front();
        d = {d[OW-2:0], m.b};
        l = l | m.e;
      end
      exp_q.push_back({l, d});
    end
    m_level++;
  endfunction

  function automatic logic [OW:0] model_pop();
    logic [OW:0] r;
    r = exp_q.pop_front();
    if (r[OW]) m_level--;
    return r;
  endfunction

  function automatic logic [OW-1:0] top_beat(logic [IW-1:0] cw, int k);
    logic [IW-1:0] sh;
    sh = cw << (k * OW);
    return sh[IW-1 -: OW];
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel_pack = s[0];
      #1;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || level !== '0) begin
        miscompares++;
        $display("FAIL reset_hold mode=%0d: rdy=%b vld=%b last=%b data=%h lvl=%0d, required all 0",
                 s, in_ready, out_valid, out_last, out_data, level);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel_pack = s[0];
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || level !== '0) begin
        miscompares++;
        $display("FAIL reset_release mode=%0d: rdy=%b vld=%b lvl=%0d, required rdy=1 vld=0 lvl=0",
                 s, in_ready, out_valid, level);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_pad_single();
    logic [IW-1:0] a;
    logic [OW-1:0] e;
    do_reset();
    sel_pack = 1'b0;
    a = rand_cw();
    in_valid = 1'b1;
    in_data = a;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k <= IW / OW; k++) begin
      @(negedge clk);
      e = (k == IW / OW) ? {a[REM-1:0], {(OW-REM){1'b0}}} : a[IW-1 - k*OW -: OW];
      vectors++;
      if (out_valid !== 1'b1 || out_data !== e || out_last !== (k == IW / OW) || level !== LW'(1)) begin
        miscompares++;
        $display("FAIL pad_beat%0d: vld=%b data=%h last=%b lvl=%0d, required vld=1 data=%h last=%b lvl=1",
                 k, out_valid, out_data, out_last, level, e, (k == IW / OW));
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || level !== '0) begin
      miscompares++;
      $display("FAIL pad_empty: vld=%b lvl=%0d, required vld=0 lvl=0", out_valid, level);
    end
  endtask

  task automatic test_fill();
    logic [IW-1:0] cw [5];
    logic [OW:0] e;
    do_reset();
    sel_pack = 1'b0;
    for (int i = 0; i < 5; i++) cw[i] = rand_cw();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = cw[i];
      model_push(cw[i]);
      @(posedge clk);
      #1;
    end
    in_data = cw[4];
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (level !== LW'(4) || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_full%0d: lvl=%0d rdy=%b, required lvl=4 rdy=0", c, level, in_ready);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int b = 1; b <= 21; b++) begin
      @(negedge clk);
      e = exp_q[0];
      vectors++;
      if (out_valid !== 1'b1 || {out_last, out_data} !== e || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_drain%0d: vld=%b beat=%h rdy=%b, required vld=1 beat=%h rdy=0",
                 b, out_valid, {out_last, out_data}, in_ready, e);
      end
      void'(model_pop());
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || level !== LW'(3)) begin
      miscompares++;
      $display("FAIL fill_reopen: rdy=%b lvl=%0d, required rdy=1 lvl=3", in_ready, level);
    end
    model_push(cw[4]);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (level !== LW'(4)) begin
      miscompares++;
      $display("FAIL fill_fifth: lvl=%0d, required 4", level);
    end
  endtask

  task automatic test_pack_span();
    logic [IW-1:0] a, b, c;
    logic [OW:0] e;
    do_reset();
    sel_pack = 1'b1;
    a = rand_cw();
    b = rand_cw();
    c = rand_cw();
    model_push(a);
    model_push(b);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = a;
    @(posedge clk);
    #1 in_data = b;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      e = (k == 20) ? {1'b1, a[REM-1:0], b[IW-1 -: OW-REM]} : exp_q[0];
      vectors++;
      if (out_valid !== 1'b1 || {out_last, out_data} !== e || exp_q[0] !== e) begin
        miscompares++;
        $display("FAIL pack_beat%0d: vld=%b beat=%h, required vld=1 beat=%h", k, out_valid, {out_last, out_data}, e);
      end
      void'(model_pop());
      @(posedge clk);
      #1;
      if (k == 0) in_valid = 1'b0;
    end
    for (int s = 0; s < 4; s++) begin
      if (s == 3) begin
        in_valid = 1'b1;
        in_data = c;
      end
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || level !== LW'(1)) begin
        miscompares++;
        $display("FAIL pack_stall%0d: vld=%b lvl=%0d, required vld=0 lvl=1", s, out_valid, level);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    model_push(c);
    @(negedge clk);
    e = {1'b1, b[15:0], c[IW-1 -: 16]};
    vectors++;
    if (out_valid !== 1'b1 || {out_last, out_data} !== e || exp_q[0] !== e || level !== LW'(2)) begin
      miscompares++;
      $display("FAIL pack_beat40: vld=%b beat=%h lvl=%0d, required vld=1 beat=%h lvl=2",
               out_valid, {out_last, out_data}, level, e);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] a, b, c;
    logic [OW:0] e;
    do_reset();
    sel_pack = 1'b0;
    a = rand_cw();
    b = rand_cw();
    c = rand_cw();
    in_valid = 1'b1;
    in_data = a;
    model_push(a);
    @(posedge clk);
    #1 in_data = b;
    model_push(b);
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k <= IW / OW; k++) begin
      @(negedge clk);
      e = exp_q[0];
      vectors++;
      if (out_valid !== 1'b1 || {out_last, out_data} !== e) begin
        miscompares++;
        $display("FAIL b2b_a%0d: vld=%b beat=%h, required vld=1 beat=%h", k, out_valid, {out_last, out_data}, e);
      end
      if (k == IW / OW) begin
        vectors++;
        if (level !== LW'(2) || in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_final: lvl=%0d rdy=%b, required lvl=2 rdy=1", level, in_ready);
        end
        model_push(c);
      end
      void'(model_pop());
      @(posedge clk);
      #1;
      if (k == IW / OW - 1) begin
        in_valid = 1'b1;
        in_data = c;
      end
      if (k == IW / OW) in_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (level !== LW'(2) || out_data !== b[IW-1 -: OW] || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_next: lvl=%0d data=%h last=%b, required lvl=2 data=%h last=0",
               level, out_data, out_last, b[IW-1 -: OW]);
    end
    for (int j = 0; j < 2 * (IW / OW + 1); j++) begin
      if (j > 0) @(negedge clk);
      e = exp_q[0];
      vectors++;
      if (out_valid !== 1'b1 || {out_last, out_data} !== e) begin
        miscompares++;
        $display("FAIL b2b_drain%0d: vld=%b beat=%h, required vld=1 beat=%h", j, out_valid, {out_last, out_data}, e);
      end
      void'(model_pop());
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_rst();
    logic [IW-1:0] a, d, x;
    do_reset();
    sel_pack = 1'b0;
    a = rand_cw();
    d = rand_cw();
    x = rand_cw();
    in_valid = 1'b1;
    in_data = a;
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== top_beat(a, k)) begin
        miscompares++;
        $display("FAIL flush_pre%0d: vld=%b data=%h, required vld=1 data=%h", k, out_valid, out_data, top_beat(a, k));
      end
      @(posedge clk);
      #1;
      if (k == 6) begin
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = x;
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || level !== '0 || out_data !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_clear: vld=%b lvl=%0d data=%h rdy=%b, required vld=0 lvl=0 data=0 rdy=1",
               out_valid, level, out_data, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== d[IW-1 -: OW] || level !== LW'(1)) begin
      miscompares++;
      $display("FAIL flush_restart: vld=%b data=%h lvl=%0d, required vld=1 data=%h lvl=1",
               out_valid, out_data, level, d[IW-1 -: OW]);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || level !== '0 || in_ready !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: vld=%b lvl=%0d rdy=%b data=%h last=%b, required all 0",
               out_valid, level, in_ready, out_data, out_last);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b1;
    in_data = a;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== a[IW-1 -: OW] || level !== LW'(1) || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_restart: vld=%b data=%h lvl=%0d, required vld=1 data=%h lvl=1",
               out_valid, out_data, level, a[IW-1 -: OW]);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random(input logic pack);
    int pushed;
    int cyc;
    logic held;
    logic [OW:0] e;
    do_reset();
    sel_pack = pack;
    pushed = 0;
    cyc = 0;
    held = 1'b0;
    while ((pushed < 16 || exp_q.size() != 0) && cyc < 4000) begin
      @(posedge clk);
      #1;
      if (!held) begin
        in_valid = (pushed < 16) && ($urandom_range(0, 2) != 0);
        if (in_valid) in_data = rand_cw();
      end
      out_ready = $urandom_range(0, 1);
      @(negedge clk);
      vectors++;
      if (out_valid !== (exp_q.size() != 0) || level !== LW'(m_level) || in_ready !== (m_level < DEPTH)) begin
        miscompares++;
        $display("FAIL rand_ctrl mode=%0d cyc=%0d: vld=%b lvl=%0d rdy=%b, required vld=%b lvl=%0d rdy=%b",
                 pack, cyc, out_valid, level, in_ready, (exp_q.size() != 0), m_level, (m_level < DEPTH));
      end
      if (out_valid === 1'b1 && exp_q.size() != 0) begin
        e = exp_q[0];
        vectors++;
        if ({out_last, out_data} !== e) begin
          miscompares++;
          $display("FAIL rand_beat mode=%0d cyc=%0d: beat=%h, required %h", pack, cyc, {out_last, out_data}, e);
        end
        if (out_ready) void'(model_pop());
      end
      held = in_valid && !in_ready;
      if (in_valid && in_ready) begin
        model_push(in_data);
        pushed++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (cyc >= 4000) begin
      miscompares++;
      $display("FAIL rand_timeout mode=%0d: pushed=%0d pending=%0d, required 16 pushed and 0 pending",
               pack, pushed, exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pad_single();
    test_fill();
    test_pack_span();
    test_back_to_back();
    test_flush_rst();
    test_random(1'b0);
    test_random(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
